// File: rtl/mastermind_pkg.sv
// rtl/mastermind_pkg.sv - shared widths, round states and history entry layout
package mastermind_pkg;

  localparam int COLOR_W = 3;
  localparam int PEGS    = 4;
  localparam int CODE_W  = PEGS * COLOR_W;
  localparam int CNT_W   = 3;
  localparam int HIST_AW = 3;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WON  = 2'd1,
    LOST = 2'd2
  } round_state_t;

  typedef struct packed {
    logic [CODE_W-1:0] guess;
    logic [CNT_W-1:0]  red;
    logic [CNT_W-1:0]  white;
  } hist_entry_t;

endpackage

// File: rtl/mastermind_history_ram.sv
// rtl/mastermind_history_ram.sv - guess history register file with per-entry valid bits
module mastermind_history_ram
  import mastermind_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_all,
  input  logic               wr_en,
  input  logic [HIST_AW-1:0] wr_addr,
  input  hist_entry_t        wr_data,
  input  logic [HIST_AW-1:0] rd_addr,
  output logic               rd_valid,
  output hist_entry_t        rd_data
);

  logic [DEPTH-1:0] valid_q, valid_d;
  hist_entry_t      mem_q [DEPTH];
  hist_entry_t      mem_d [DEPTH];
  logic             rd_valid_q, rd_valid_d;
  hist_entry_t      rd_data_q, rd_data_d;
  logic             wr_in_range, rd_in_range, rd_hit;

  assign wr_in_range = ({1'b0, wr_addr} < (HIST_AW + 1)'(DEPTH));
  assign rd_in_range = ({1'b0, rd_addr} < (HIST_AW + 1)'(DEPTH));

  always_comb begin
    valid_d = valid_q;
    mem_d   = mem_q;
    if (clr_all) begin
      valid_d = '0;
    end else if (wr_en && wr_in_range) begin
      mem_d[wr_addr]   = wr_data;
      valid_d[wr_addr] = 1'b1;
    end
  end

  // Read sees pre-edge contents, so a same-edge write to the selected slot reads as invalid.
  always_comb begin
    rd_hit     = rd_in_range && valid_q[rd_addr];
    rd_valid_d = rd_hit;
    rd_data_d  = rd_hit ? mem_q[rd_addr] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/mastermind_round_tracker.sv
// rtl/mastermind_round_tracker.sv - per-game guess counter, win/loss FSM and history readback
module mastermind_round_tracker
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 8,
  parameter int PEGS        = 4,
  parameter int COLOR_W     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_game,
  input  logic                    score_valid,
  input  logic [PEGS*COLOR_W-1:0] guess,
  input  logic [2:0]              red,
  input  logic [2:0]              white,
  input  logic [2:0]              hist_sel,
  output logic                    ready,
  output logic [3:0]              guess_count,
  output logic                    won,
  output logic                    lost,
  output logic [2:0]              last_red,
  output logic [2:0]              last_white,
  output logic                    score_err,
  output logic                    hist_valid,
  output logic [PEGS*COLOR_W-1:0] hist_guess,
  output logic [2:0]              hist_red,
  output logic [2:0]              hist_white
);

  localparam logic [3:0] PEGS_N = 4'(PEGS);
  localparam logic [3:0] MAX_N  = 4'(MAX_GUESSES);

  round_state_t state_q, state_d;
  logic [3:0]   count_q, count_d;
  logic [2:0]   last_red_q, last_red_d;
  logic [2:0]   last_white_q, last_white_d;
  logic         score_err_q, score_err_d;
  logic         legal, full_red;
  logic         wr_en, clr_all;
  hist_entry_t  wr_data, rd_data;
  logic         rd_valid;

  // Sum is taken 4 bits wide so e.g. 7+7 cannot wrap into a legal value.
  assign full_red = ({1'b0, red} == PEGS_N);
  assign legal    = ({1'b0, red} <= PEGS_N) &&
                    (({1'b0, red} + {1'b0, white}) <= PEGS_N) &&
                    (!full_red || (white == 3'd0));

  assign wr_data.guess = guess;
  assign wr_data.red   = red;
  assign wr_data.white = white;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_red_d   = last_red_q;
    last_white_d = last_white_q;
    score_err_d  = 1'b0;
    wr_en        = 1'b0;
    clr_all      = 1'b0;
    if (new_game) begin
      state_d      = PLAY;
      count_d      = 4'd0;
      last_red_d   = 3'd0;
      last_white_d = 3'd0;
      clr_all      = 1'b1;
    end else if (state_q == PLAY && score_valid) begin
      if (legal) begin
        wr_en        = 1'b1;
        count_d      = count_q + 4'd1;
        last_red_d   = red;
        last_white_d = white;
        if (full_red) begin
          state_d = WON;
        end else if (count_d == MAX_N) begin
          state_d = LOST;
        end
      end else begin
        score_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= PLAY;
      count_q      <= 4'd0;
      last_red_q   <= 3'd0;
      last_white_q <= 3'd0;
      score_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_red_q   <= last_red_d;
      last_white_q <= last_white_d;
      score_err_q  <= score_err_d;
    end
  end

  mastermind_history_ram #(
    .DEPTH (MAX_GUESSES)
  ) u_hist (
    .clk      (clk),
    .rst      (reset),
    .clr_all  (clr_all),
    .wr_en    (wr_en),
    .wr_addr  (count_q[HIST_AW-1:0]),
    .wr_data  (wr_data),
    .rd_addr  (hist_sel),
    .rd_valid (rd_valid),
    .rd_data  (rd_data)
  );

  assign ready       = (state_q == PLAY);
  assign won         = (state_q == WON);
  assign lost        = (state_q == LOST);
  assign guess_count = count_q;
  assign last_red    = last_red_q;
  assign last_white  = last_white_q;
  assign score_err   = score_err_q;
  assign hist_valid  = rd_valid;
  assign hist_guess  = rd_data.guess;
  assign hist_red    = rd_data.red;
  assign hist_white  = rd_data.white;

endmodule

// File: tb/tb_mastermind_round_tracker.sv
// tb/tb_mastermind_round_tracker.sv - directed self-checking bench for mastermind_round_tracker
module tb_mastermind_round_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_game = 1'b0;
  logic        score_valid = 1'b0;
  logic [11:0] guess = '0;
  logic [2:0]  red = '0;
  logic [2:0]  white = '0;
  logic [2:0]  hist_sel = '0;
  logic        ready, won, lost, score_err, hist_valid;
  logic [3:0]  guess_count;
  logic [2:0]  last_red, last_white, hist_red, hist_white;
  logic [11:0] hist_guess;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mastermind_round_tracker dut (
    .clk         (clk),
    .reset       (reset),
    .new_game    (new_game),
    .score_valid (score_valid),
    .guess       (guess),
    .red         (red),
    .white       (white),
    .hist_sel    (hist_sel),
    .ready       (ready),
    .guess_count (guess_count),
    .won         (won),
    .lost        (lost),
    .last_red    (last_red),
    .last_white  (last_white),
    .score_err   (score_err),
    .hist_valid  (hist_valid),
    .hist_guess  (hist_guess),
    .hist_red    (hist_red),
    .hist_white  (hist_white)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic score(input logic [11:0] g, input logic [2:0] r, input logic [2:0] w);
    guess = g;
    red = r;
    white = w;
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  task automatic restart();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_count", 32'(guess_count), 32'd0);
    chk("rst_won", 32'(won), 32'd0);
    chk("rst_lost", 32'(lost), 32'd0);
    chk("rst_hvalid", 32'(hist_valid), 32'd0);
    chk("rst_hguess", 32'(hist_guess), 32'd0);
    reset = 1'b0;
    tick();

    // game 1: (1,2) (2,1) (4,0) -> win on third
    hist_sel = 3'd0;
    score(12'h111, 3'd1, 3'd2);
    chk("g1_cnt1", 32'(guess_count), 32'd1);
    chk("g1_samewr_hvalid", 32'(hist_valid), 32'd0);
    chk("g1_samewr_hred", 32'(hist_red), 32'd0);
    score(12'h222, 3'd2, 3'd1);
    chk("g1_cnt2", 32'(guess_count), 32'd2);
    chk("g1_e0_hvalid", 32'(hist_valid), 32'd1);
    chk("g1_e0_hwhite", 32'(hist_white), 32'd2);
    chk("g1_e0_hguess", 32'(hist_guess), 32'h111);
    score(12'h333, 3'd4, 3'd0);
    chk("g1_cnt3", 32'(guess_count), 32'd3);
    chk("g1_won", 32'(won), 32'd1);
    chk("g1_ready", 32'(ready), 32'd0);
    chk("g1_lastred", 32'(last_red), 32'd4);
    hist_sel = 3'd1;
    tick();
    chk("g1_h1_valid", 32'(hist_valid), 32'd1);
    chk("g1_h1_red", 32'(hist_red), 32'd2);
    chk("g1_h1_white", 32'(hist_white), 32'd1);
    chk("g1_h1_guess", 32'(hist_guess), 32'h222);
    hist_sel = 3'd3;
    tick();
    chk("g1_h3_valid", 32'(hist_valid), 32'd0);

    // game 2: eight (0,1) -> lost; ninth ignored
    restart();
    chk("g2_ng_won", 32'(won), 32'd0);
    chk("g2_ng_cnt", 32'(guess_count), 32'd0);
    for (int i = 0; i < 8; i++) begin
      score(12'(i), 3'd0, 3'd1);
      chk("g2_lost_early", 32'(lost), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("g2_cnt8", 32'(guess_count), 32'd8);
    chk("g2_ready", 32'(ready), 32'd0);
    score(12'hfff, 3'd4, 3'd0);
    chk("g2_9th_cnt", 32'(guess_count), 32'd8);
    chk("g2_9th_won", 32'(won), 32'd0);
    chk("g2_9th_lost", 32'(lost), 32'd1);
    chk("g2_9th_err", 32'(score_err), 32'd0);
    hist_sel = 3'd7;
    tick();
    chk("g2_h7_valid", 32'(hist_valid), 32'd1);
    chk("g2_h7_guess", 32'(hist_guess), 32'd7);
    chk("g2_h7_white", 32'(hist_white), 32'd1);

    // game 3: seven (1,1) then (4,0) on the last guess
    restart();
    for (int i = 0; i < 7; i++) score(12'h555, 3'd1, 3'd1);
    chk("g3_cnt7", 32'(guess_count), 32'd7);
    chk("g3_ready7", 32'(ready), 32'd1);
    score(12'h777, 3'd4, 3'd0);
    chk("g3_won", 32'(won), 32'd1);
    chk("g3_lost", 32'(lost), 32'd0);
    chk("g3_cnt8", 32'(guess_count), 32'd8);

    // game 4: illegal scores
    restart();
    score(12'h123, 3'd1, 3'd0);
    score(12'h0aa, 3'd3, 3'd2);
    chk("g4_err32", 32'(score_err), 32'd1);
    chk("g4_cnt32", 32'(guess_count), 32'd1);
    tick();
    chk("g4_err_clr", 32'(score_err), 32'd0);
    score(12'h0bb, 3'd5, 3'd0);
    chk("g4_err50", 32'(score_err), 32'd1);
    chk("g4_cnt50", 32'(guess_count), 32'd1);
    score(12'h0cc, 3'd4, 3'd1);
    chk("g4_err41", 32'(score_err), 32'd1);
    chk("g4_cnt41", 32'(guess_count), 32'd1);
    chk("g4_lastred", 32'(last_red), 32'd1);
    chk("g4_ready", 32'(ready), 32'd1);
    hist_sel = 3'd1;
    tick();
    chk("g4_err_off", 32'(score_err), 32'd0);
    chk("g4_h1_valid", 32'(hist_valid), 32'd0);
    chk("g4_h1_guess", 32'(hist_guess), 32'd0);

    // game 4 continued: new_game collides with score_valid after 3 guesses
    score(12'h124, 3'd2, 3'd0);
    score(12'h125, 3'd0, 3'd4);
    chk("g5_cnt3", 32'(guess_count), 32'd3);
    new_game = 1'b1;
    score(12'h126, 3'd4, 3'd0);
    new_game = 1'b0;
    chk("g5_cnt0", 32'(guess_count), 32'd0);
    chk("g5_ready", 32'(ready), 32'd1);
    chk("g5_won", 32'(won), 32'd0);
    chk("g5_lastwhite", 32'(last_white), 32'd0);
    hist_sel = 3'd0;
    tick();
    chk("g5_h0_valid", 32'(hist_valid), 32'd0);
    chk("g5_h0_guess", 32'(hist_guess), 32'd0);
    chk("g5_h0_red", 32'(hist_red), 32'd0);

    // asynchronous reset mid-game
    score(12'h321, 3'd2, 3'd2);
    score(12'h322, 3'd4, 3'd0);
    chk("g6_won_pre", 32'(won), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("g6_rst_cnt", 32'(guess_count), 32'd0);
    chk("g6_rst_won", 32'(won), 32'd0);
    chk("g6_rst_ready", 32'(ready), 32'd1);
    chk("g6_rst_lastred", 32'(last_red), 32'd0);
    chk("g6_rst_hvalid", 32'(hist_valid), 32'd0);
    tick();
    reset = 1'b0;
    hist_sel = 3'd0;
    score(12'habc, 3'd2, 3'd2);
    chk("g6_cnt1", 32'(guess_count), 32'd1);
    tick();
    chk("g6_h0_valid", 32'(hist_valid), 32'd1);
    chk("g6_h0_guess", 32'(hist_guess), 32'habc);
    chk("g6_h0_red", 32'(hist_red), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
